// File: rtl/peaks_sequencer_if.sv
// Stream bundle for the peak sequencer: FFT bin input stream and peak entry output stream.
interface peaks_sequencer_if #(
   parameter int IN_W   = 24,
   parameter int FREQ_W = 8,
   parameter int AMPL_W = 16,
   parameter int TIME_W = 14
) ();
   logic              bin_valid;
   logic              bin_ready;
   logic [IN_W-1:0]   bin_data;
   logic              bin_last;

   logic              out_valid;
   logic              out_ready;
   logic [AMPL_W-1:0] out_ampl;
   logic [FREQ_W-1:0] out_freq;
   logic [TIME_W-1:0] out_time;
   logic              out_last;

   // Environment side: FFT source plus downstream consumer.
   modport master (
      output bin_valid, bin_data, bin_last, out_ready,
      input  bin_ready, out_valid, out_ampl, out_freq, out_time, out_last
   );

   // Sequencer side.
   modport slave (
      input  bin_valid, bin_data, bin_last, out_ready,
      output bin_ready, out_valid, out_ampl, out_freq, out_time, out_last
   );
endinterface

// File: rtl/peaks_sequencer.sv
// Peak finder sequencer: buffers one FFT frame, strobes the peak finder, captures its
// results after a settle window and drains them as a valid/ready stream. The first two
// captures after reset are dropped while the finder's 3-frame window fills.
module peaks_sequencer #(
   parameter int FREQS         = 256,
   parameter int PEAKS         = 6,
   parameter int IN_W          = 24,
   parameter int FREQ_W        = 8,
   parameter int AMPL_W        = 16,
   parameter int TIME_W        = 14,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                         CLOCK_50,
   input  logic                         reset_n,
   peaks_sequencer_if.slave             bus,
   output logic [FREQS-1:0][IN_W-1:0]   frame_out,
   output logic                         peaks_valid,
   output logic                         peaks_reset,
   input  logic [PEAKS-1:0][AMPL_W-1:0] pk_ampl,
   input  logic [PEAKS-1:0][FREQ_W-1:0] pk_freq,
   input  logic [TIME_W-1:0]            pk_count,
   output logic                         frame_err
);
   localparam int WR_W = (FREQS > 1) ? $clog2(FREQS) : 1;
   localparam int RD_W = (PEAKS > 1) ? $clog2(PEAKS) : 1;
   localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [WR_W-1:0] LAST_BIN = WR_W'(FREQS - 1);
   localparam logic [RD_W-1:0] LAST_PK  = RD_W'(PEAKS - 1);
   localparam logic [ST_W-1:0] LAST_ST  = ST_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {FILL, ARM, SETTLE, CAPTURE, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [WR_W-1:0]   wr_idx_q, wr_idx_d;
   logic [RD_W-1:0]   rd_idx_q, rd_idx_d;
   logic [ST_W-1:0]   settle_q, settle_d;
   logic [1:0]        prime_cnt_q, prime_cnt_d;
   logic              bin_ready_q, bin_ready_d;
   logic              peaks_valid_q, peaks_valid_d;
   logic              out_valid_q, out_valid_d;
   logic              frame_err_q, frame_err_d;
   logic              peaks_reset_q;
   logic [IN_W-1:0]   frame_q [FREQS];
   logic [IN_W-1:0]   frame_d [FREQS];
   logic [AMPL_W-1:0] shadow_ampl_q [PEAKS];
   logic [AMPL_W-1:0] shadow_ampl_d [PEAKS];
   logic [FREQ_W-1:0] shadow_freq_q [PEAKS];
   logic [FREQ_W-1:0] shadow_freq_d [PEAKS];
   logic [TIME_W-1:0] shadow_count_q, shadow_count_d;

   logic bin_accept;
   logic out_accept;

   // bin_ready_q is only high in FILL, so it doubles as the FILL qualifier.
   assign bin_accept = bus.bin_valid && bin_ready_q;
   assign out_accept = out_valid_q && bus.out_ready;

   // Next-state, frame buffer, shadow capture and registered strobes.
   always_comb begin
      state_d        = state_q;
      wr_idx_d       = wr_idx_q;
      rd_idx_d       = rd_idx_q;
      settle_d       = settle_q;
      prime_cnt_d    = prime_cnt_q;
      frame_err_d    = frame_err_q;
      frame_d        = frame_q;
      shadow_ampl_d  = shadow_ampl_q;
      shadow_freq_d  = shadow_freq_q;
      shadow_count_d = shadow_count_q;
      case (state_q)
         FILL: begin
            if (bin_accept) begin
               frame_d[wr_idx_q] = bus.bin_data;
               // Framing is by count; bin_last only feeds the sticky error flag.
               if (bus.bin_last != (wr_idx_q == LAST_BIN)) begin
                  frame_err_d = 1'b1;
               end
               if (wr_idx_q == LAST_BIN) begin
                  wr_idx_d = '0;
                  state_d  = ARM;
               end else begin
                  wr_idx_d = wr_idx_q + 1'b1;
               end
            end
         end
         ARM: begin
            settle_d = '0;
            state_d  = SETTLE;
         end
         SETTLE: begin
            if (settle_q == LAST_ST) begin
               state_d = CAPTURE;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         CAPTURE: begin
            for (int i = 0; i < PEAKS; i++) begin
               shadow_ampl_d[i] = pk_ampl[i];
               shadow_freq_d[i] = pk_freq[i];
            end
            shadow_count_d = pk_count;
            if (prime_cnt_q < 2'd2) begin
               prime_cnt_d = prime_cnt_q + 2'd1;
               state_d     = FILL;
            end else begin
               rd_idx_d = '0;
               state_d  = DRAIN;
            end
         end
         DRAIN: begin
            if (out_accept) begin
               if (rd_idx_q == LAST_PK) begin
                  rd_idx_d = '0;
                  state_d  = FILL;
               end else begin
                  rd_idx_d = rd_idx_q + 1'b1;
               end
            end
         end
         default: state_d = FILL;
      endcase
      // Strobes are registered images of the state being entered.
      bin_ready_d   = (state_d == FILL);
      peaks_valid_d = (state_d == ARM);
      out_valid_d   = (state_d == DRAIN);
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state_q        <= FILL;
         wr_idx_q       <= '0;
         rd_idx_q       <= '0;
         settle_q       <= '0;
         prime_cnt_q    <= '0;
         bin_ready_q    <= 1'b0;
         peaks_valid_q  <= 1'b0;
         out_valid_q    <= 1'b0;
         frame_err_q    <= 1'b0;
         peaks_reset_q  <= 1'b1;
         shadow_count_q <= '0;
         for (int i = 0; i < FREQS; i++) frame_q[i] <= '0;
         for (int i = 0; i < PEAKS; i++) begin
            shadow_ampl_q[i] <= '0;
            shadow_freq_q[i] <= '0;
         end
      end else begin
         state_q        <= state_d;
         wr_idx_q       <= wr_idx_d;
         rd_idx_q       <= rd_idx_d;
         settle_q       <= settle_d;
         prime_cnt_q    <= prime_cnt_d;
         bin_ready_q    <= bin_ready_d;
         peaks_valid_q  <= peaks_valid_d;
         out_valid_q    <= out_valid_d;
         frame_err_q    <= frame_err_d;
         peaks_reset_q  <= 1'b0;
         shadow_count_q <= shadow_count_d;
         frame_q        <= frame_d;
         shadow_ampl_q  <= shadow_ampl_d;
         shadow_freq_q  <= shadow_freq_d;
      end
   end

   generate
      for (genvar gi = 0; gi < FREQS; gi++) begin : g_frame
         assign frame_out[gi] = frame_q[gi];
      end
   endgenerate

   // Output entry is read straight from the shadow bank, so it holds while stalled.
   assign bus.bin_ready = bin_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_ampl  = shadow_ampl_q[rd_idx_q];
   assign bus.out_freq  = shadow_freq_q[rd_idx_q];
   assign bus.out_time  = shadow_count_q;
   assign bus.out_last  = out_valid_q && (rd_idx_q == LAST_PK);
   assign peaks_valid   = peaks_valid_q;
   assign peaks_reset   = peaks_reset_q;
   assign frame_err     = frame_err_q;
endmodule

// File: tb/tb_peaks_sequencer.sv
// Randomized bench for peaks_sequencer against a transaction-level reference model.
module tb_peaks_sequencer;
   localparam int FREQS = 256, PEAKS = 6, IN_W = 24, FREQ_W = 8;
   localparam int AMPL_W = 16, TIME_W = 14, SETTLE = 2;

   logic clk = 1'b0;
   logic reset_n;
   logic [FREQS-1:0][IN_W-1:0]   frame_out;
   logic                         peaks_valid, peaks_reset, frame_err;
   logic [PEAKS-1:0][AMPL_W-1:0] pk_ampl;
   logic [PEAKS-1:0][FREQ_W-1:0] pk_freq;
   logic [TIME_W-1:0]            pk_count;

   always #5 clk = ~clk;

   peaks_sequencer_if #(.IN_W(IN_W), .FREQ_W(FREQ_W), .AMPL_W(AMPL_W), .TIME_W(TIME_W)) bus_if ();

   peaks_sequencer #(
      .FREQS(FREQS), .PEAKS(PEAKS), .IN_W(IN_W), .FREQ_W(FREQ_W),
      .AMPL_W(AMPL_W), .TIME_W(TIME_W), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .CLOCK_50(clk), .reset_n(reset_n), .bus(bus_if),
      .frame_out(frame_out), .peaks_valid(peaks_valid), .peaks_reset(peaks_reset),
      .pk_ampl(pk_ampl), .pk_freq(pk_freq), .pk_count(pk_count), .frame_err(frame_err)
   );

   typedef struct packed {
      logic [AMPL_W-1:0] ampl;
      logic [FREQ_W-1:0] freq;
      logic [TIME_W-1:0] tm;
      logic              last;
   } entry_t;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   entry_t          q[$];
   logic [IN_W-1:0] m_frame [FREQS];
   int  m_idx = 0, prime = 0, popped = 0, cyc = 0;
   int  pulse_cyc = -1, cap_cyc = -1;
   bit  busy = 0, m_err = 0, rst_prev = 1;

   // Stimulus controls
   bit stall_arm = 0, rst_arm = 0, rst_hold = 0, rand_ready = 0;
   int stall_cnt = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Peak finder results change every cycle; out_ready / mid-drain reset driven here.
   initial begin
      bus_if.out_ready = 1'b1;
      pk_ampl = '0; pk_freq = '0; pk_count = '0;
      forever begin
         @(posedge clk); #1;
         for (int k = 0; k < PEAKS; k++) begin
            pk_ampl[k] = ($urandom_range(0, 3) == 0) ? '0 : AMPL_W'($urandom);
            pk_freq[k] = FREQ_W'($urandom);
         end
         pk_count = TIME_W'($urandom);
         if (rst_hold) begin
            reset_n  = 1'b1;
            rst_hold = 0;
         end else if (rst_arm && bus_if.out_valid && q.size() > 0 && (PEAKS - q.size()) == 3) begin
            reset_n  = 1'b0;
            rst_arm  = 0;
            rst_hold = 1;
         end
         if (stall_cnt > 0) begin
            bus_if.out_ready = 1'b0;
            stall_cnt--;
         end else if (stall_arm && bus_if.out_valid && q.size() > 0 && (PEAKS - q.size()) == 2) begin
            bus_if.out_ready = 1'b0;
            stall_cnt = 19;
            stall_arm = 0;
         end else begin
            bus_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   // Monitor: compare against the model, then advance the model by this cycle.
   always @(negedge clk) begin
      entry_t e;
      cyc++;
      check_val("peaks_reset", 64'(peaks_reset), 64'(rst_prev));
      check_val("bin_ready", 64'(bus_if.bin_ready), 64'(!busy && !rst_prev));
      check_val("peaks_valid", 64'(peaks_valid), 64'(cyc == pulse_cyc));
      check_val("frame_err", 64'(frame_err), 64'(m_err));
      check_val("out_valid", 64'(bus_if.out_valid), 64'(q.size() > 0));
      if (bus_if.out_valid === 1'b1 && q.size() > 0) begin
         e = q[0];
         check_val("out_ampl", 64'(bus_if.out_ampl), 64'(e.ampl));
         check_val("out_freq", 64'(bus_if.out_freq), 64'(e.freq));
         check_val("out_time", 64'(bus_if.out_time), 64'(e.tm));
         check_val("out_last", 64'(bus_if.out_last), 64'(e.last));
      end
      if (cyc == pulse_cyc) begin
         $display("[%0d] peaks strobe", cyc);
         for (int b = 0; b < FREQS; b++)
            check_val("frame_bin", 64'(frame_out[b]), 64'(m_frame[b]));
      end

      if (reset_n !== 1'b1) begin
         q.delete();
         for (int b = 0; b < FREQS; b++) m_frame[b] = '0;
         m_idx = 0; prime = 0; busy = 0; m_err = 0;
         pulse_cyc = -1; cap_cyc = -1;
      end else begin
         if (bus_if.bin_valid && bus_if.bin_ready) begin
            m_frame[m_idx] = bus_if.bin_data;
            if (bus_if.bin_last != (m_idx == FREQS - 1)) m_err = 1;
            if (m_idx == FREQS - 1) begin
               m_idx = 0; busy = 1;
               pulse_cyc = cyc + 1;
               cap_cyc   = cyc + 2 + SETTLE;
            end else begin
               m_idx++;
            end
         end
         if (cyc == cap_cyc) begin
            if (prime < 2) begin
               prime++;
               busy = 0;
            end else begin
               for (int k = 0; k < PEAKS; k++) begin
                  e.ampl = pk_ampl[k];
                  e.freq = pk_freq[k];
                  e.tm   = pk_count;
                  e.last = (k == PEAKS - 1);
                  q.push_back(e);
               end
            end
         end
         if (bus_if.out_valid && bus_if.out_ready && q.size() > 0) begin
            e = q.pop_front();
            popped++;
            $display("[%0d] out entry ampl=%0h freq=%0h time=%0h last=%0b",
                     cyc, e.ampl, e.freq, e.tm, e.last);
            if (q.size() == 0) busy = 0;
         end
      end
      rst_prev = (reset_n !== 1'b1);
   end

   // Stream one frame; bad_last >= 0 puts bin_last at that index instead of the end.
   task automatic send_frame(input bit ramp, input int bad_last);
      int i = 0;
      int guard = 0;
      bit acc;
      while (i < FREQS) begin
         bus_if.bin_valid = ramp ? 1'b1 : ($urandom_range(0, 3) != 0);
         bus_if.bin_data  = ramp ? IN_W'(i) : IN_W'($urandom);
         bus_if.bin_last  = (bad_last >= 0) ? (i == bad_last) : (i == FREQS - 1);
         @(negedge clk);
         acc = bus_if.bin_valid && (bus_if.bin_ready === 1'b1);
         @(posedge clk); #1;
         if (acc) i++;
         guard++;
         if (guard > 4000) begin
            check_val("bin_wait_timeout", 64'(i), 64'(FREQS));
            break;
         end
      end
      bus_if.bin_valid = 1'b0;
      bus_if.bin_last  = 1'b0;
      $display("[%0d] frame sent (bad_last=%0d)", cyc, bad_last);
   endtask

   initial begin
      int w;
      reset_n = 1'b0;
      bus_if.bin_valid = 1'b0;
      bus_if.bin_data  = '0;
      bus_if.bin_last  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_out_ampl", 64'(bus_if.out_ampl), 64'd0);
      check_val("rst_out_freq", 64'(bus_if.out_freq), 64'd0);
      check_val("rst_out_time", 64'(bus_if.out_time), 64'd0);
      check_val("rst_out_last", 64'(bus_if.out_last), 64'd0);
      check_val("rst_frame_first", 64'(frame_out[0]), 64'd0);
      check_val("rst_frame_last", 64'(frame_out[FREQS-1]), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      for (int f = 0; f < 3; f++) send_frame(1'b1, -1);   // priming + first output
      send_frame(1'b0, -1);
      stall_arm = 1;                                       // stall this frame's drain
      send_frame(1'b0, 100);                               // misaligned bin_last
      send_frame(1'b0, -1);
      rst_arm = 1;                                         // reset during this drain
      send_frame(1'b0, -1);                                // primed after reset
      send_frame(1'b0, -1);
      rand_ready = 1;
      send_frame(1'b0, -1);
      send_frame(1'b0, -1);

      w = 0;
      while ((busy || q.size() > 0) && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 3000) check_val("drain_timeout", 64'(q.size()), 64'd0);
      // 3 full drains, a drain cut at entry 3, then 2 full drains after re-priming.
      check_val("total_entries", 64'(popped), 64'(5 * PEAKS + 3));
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
